// File: rtl/hex_digit_counter.sv
// hex_digit_counter
//
// Source stage for the 7-segment hex decoder. Holds a 4-bit digit and steps
// it up or down (mod 16) at a rate derived from the system clock. A parallel
// load overrides everything else. Cascaded digit stages are fed by the
// tick/wrap strobes.
//
// Ports:
//   clock      in   1  system clock, rising edge
//   resetn     in   1  asynchronous active-low reset
//   enable     in   1  runs the rate divider; low freezes the divider and digit
//   speed      in   2  rate select: 00 every cycle, 01 CLK_HZ, 10 2*CLK_HZ,
//                      11 4*CLK_HZ cycles per step
//   up         in   1  step direction, 1 = +1, 0 = -1
//   load       in   1  synchronous parallel load strobe
//   load_value in   4  value written to digit on load
//   digit      out  4  current digit value (registered)
//   tick       out  1  one-cycle pulse in the cycle a stepped digit first appears
//   wrap       out  1  pulses together with tick when the step wrapped
//
// There is no valid/ready handshake: tick and wrap are plain one-cycle
// strobes, valid in the same cycle as the new digit and never stalled.

module hex_digit_counter #(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       enable,
    input  logic [1:0] speed,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic [3:0] digit,
    output logic       tick,
    output logic       wrap
);

    // Divider is wide enough to hold the longest period minus one.
    localparam int unsigned DIV_BITS =
        ($clog2(4 * CLK_HZ) < 1) ? 1 : $clog2(4 * CLK_HZ);

    logic [DIV_BITS-1:0] div;
    logic [1:0]          speed_q;
    logic                wrap_next;

    // Reload value for the divider: period for the given rate minus one.
    function automatic logic [DIV_BITS-1:0] period_m1(input logic [1:0] s);
        logic [31:0] p;
        case (s)
            2'b00:   p = 32'd1;
            2'b01:   p = 32'(CLK_HZ);
            2'b10:   p = 32'(2 * CLK_HZ);
            default: p = 32'(4 * CLK_HZ);
        endcase
        return DIV_BITS'(p - 32'd1);
    endfunction

    // A step wraps when leaving 15 upward or 0 downward.
    assign wrap_next = up ? (digit == 4'hF) : (digit == 4'h0);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            digit   <= 4'h0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
            div     <= '0;
            speed_q <= 2'b00;
        end else begin
            speed_q <= speed;
            if (load) begin
                // Load beats everything, including a pending step.
                digit <= load_value;
                div   <= period_m1(speed);
                tick  <= 1'b0;
                wrap  <= 1'b0;
            end else if (speed != speed_q) begin
                // New rate restarts the period from the new length; a step
                // that would have fired on this edge is dropped.
                div  <= period_m1(speed);
                tick <= 1'b0;
                wrap <= 1'b0;
            end else if (enable && (div == '0)) begin
                digit <= up ? (digit + 4'd1) : (digit - 4'd1);
                div   <= period_m1(speed_q);
                tick  <= 1'b1;
                wrap  <= wrap_next;
            end else if (enable) begin
                div  <= div - DIV_BITS'(1);
                tick <= 1'b0;
                wrap <= 1'b0;
            end else begin
                // Disabled: divider and digit freeze so the period resumes
                // where it left off.
                tick <= 1'b0;
                wrap <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hex_digit_counter.sv
// Self-checking bench for hex_digit_counter with CLK_HZ = 4 (P = 1, 4, 8, 16).
// Expected {digit, tick, wrap} triples are pushed into a queue as each cycle
// of stimulus is driven and popped/compared after the following clock edge.

module tb_hex_digit_counter;

    logic       clock;
    logic       resetn;
    logic       enable;
    logic [1:0] speed;
    logic       up;
    logic       load;
    logic [3:0] load_value;
    logic [3:0] digit;
    logic       tick;
    logic       wrap;

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] exp_q[$];

    hex_digit_counter #(.CLK_HZ(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .enable     (enable),
        .speed      (speed),
        .up         (up),
        .load       (load),
        .load_value (load_value),
        .digit      (digit),
        .tick       (tick),
        .wrap       (wrap)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: run time expired, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Push the expectation, run one edge, sample #1 later and compare.
    task automatic expect_cycle(input string tag, input logic [3:0] d,
                                input logic t, input logic w);
        logic [5:0] e;
        exp_q.push_back({d, t, w});
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check({tag, "_digit"}, 32'(digit), 32'(e[5:2]));
        check({tag, "_tick"},  32'(tick),  32'(e[1]));
        check({tag, "_wrap"},  32'(wrap),  32'(e[0]));
    endtask

    // Cycles with no step: digit constant, no strobes.
    task automatic expect_idle(input string tag, input logic [3:0] d,
                               input int n);
        for (int i = 0; i < n; i++) expect_cycle(tag, d, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        resetn     = 1'b0;
        enable     = 1'b0;
        speed      = 2'b00;
        up         = 1'b1;
        load       = 1'b0;
        load_value = 4'h0;

        // Reset state
        #12;
        check("rst_digit", 32'(digit), 32'd0);
        check("rst_tick",  32'(tick),  32'd0);
        check("rst_wrap",  32'(wrap),  32'd0);

        // 1: fast count, steps every cycle, wrap only on 15 -> 0
        @(posedge clock); #1;
        resetn = 1'b1;
        enable = 1'b1;
        for (int i = 1; i <= 17; i++)
            expect_cycle("fast", 4'(i % 16), 1'b1, (i % 16) == 0);

        // 2: divided rate from reset with speed = 01
        resetn = 1'b0;
        #1;
        speed = 2'b01;
        #1;
        resetn = 1'b1;
        expect_cycle("div_first", 4'd0, 1'b0, 1'b0);   // rate-change edge
        for (int j = 1; j <= 3; j++) begin
            expect_idle("div4_wait", 4'(j - 1), 3);
            expect_cycle("div4_tick", 4'(j), 1'b1, 1'b0);
        end
        speed = 2'b11;
        expect_cycle("div16_chg", 4'd3, 1'b0, 1'b0);
        expect_idle("div16_wait", 4'd3, 15);
        expect_cycle("div16_tick", 4'd4, 1'b1, 1'b0);
        expect_idle("div16_wait2", 4'd4, 15);
        expect_cycle("div16_tick2", 4'd5, 1'b1, 1'b0);

        // 3: load 1 at speed 00, then count down through the wrap
        speed      = 2'b00;
        up         = 1'b0;
        load       = 1'b1;
        load_value = 4'd1;
        expect_cycle("dn_load", 4'd1, 1'b0, 1'b0);
        load = 1'b0;
        expect_cycle("dn_0",  4'd0,  1'b1, 1'b0);
        expect_cycle("dn_15", 4'd15, 1'b1, 1'b1);
        expect_cycle("dn_14", 4'd14, 1'b1, 1'b0);

        // 4: load beats a pending step at speed 01
        speed = 2'b01;
        up    = 1'b1;
        expect_cycle("ld_chg", 4'd14, 1'b0, 1'b0);
        expect_idle("ld_wait", 4'd14, 3);              // div now 0
        load       = 1'b1;
        load_value = 4'd9;
        expect_cycle("ld_win", 4'd9, 1'b0, 1'b0);
        load = 1'b0;
        expect_idle("ld_after", 4'd9, 3);
        expect_cycle("ld_tick", 4'd10, 1'b1, 1'b0);

        // 5: enable freeze at speed 10
        speed = 2'b10;
        expect_cycle("frz_chg", 4'd10, 1'b0, 1'b0);   // div = 7
        expect_idle("frz_count", 4'd10, 3);           // div = 4
        enable = 1'b0;
        expect_idle("frz_off", 4'd10, 20);
        enable = 1'b1;
        expect_idle("frz_resume", 4'd10, 4);
        expect_cycle("frz_tick", 4'd11, 1'b1, 1'b0);

        // 6: async reset between edges while digit = 7 and tick is high
        speed      = 2'b00;
        load       = 1'b1;
        load_value = 4'd6;
        expect_cycle("ar_load", 4'd6, 1'b0, 1'b0);
        load = 1'b0;
        expect_cycle("ar_step", 4'd7, 1'b1, 1'b0);
        resetn = 1'b0;
        #2;   // still well before the next rising edge
        check("ar_digit", 32'(digit), 32'd0);
        check("ar_tick",  32'(tick),  32'd0);
        check("ar_wrap",  32'(wrap),  32'd0);
        enable = 1'b0;
        #1;
        resetn = 1'b1;
        expect_cycle("ar_hold", 4'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
